// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Patterns are active-low, bit 6 = segment g, bit 0 = segment a.
package seg_scan_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0011000;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        SYNC,
        COLLECT
    } frame_state_t;

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational active-low seven-segment pattern to hex nibble decoder.
// SEG_SCAN_BLANK_ZERO_EN: blank pattern decodes to 0 without error.
module seg7_to_nibble
    import seg_scan_pkg::*;
(
    input  logic [SEG_W-1:0]    seg,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                err
);

    always_comb begin
        nibble = '0;
        err    = 1'b0;
        case (seg)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
`ifdef SEG_SCAN_BLANK_ZERO_EN
            // Leading-zero suppression: a dark digit reads as zero.
            SEG_BLANK: nibble = 4'h0;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex nibbles from a multiplexed active-low seven-segment scan bus
// and presents each full frame on valid/ready. Option: SEG_SCAN_BLANK_ZERO_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_value,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    out_overrun
);

    localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]      seg_q, seg_prev;
    logic [NUM_DIGITS-1:0] dig_q, dig_prev;
    logic [RUN_W-1:0]      run_q, run_d;
    logic                  cap_q, cap_d;
    logic                  same_c;

    logic [NIBBLE_W-1:0]   cap_nib;
    logic                  cap_err;

    frame_state_t          state_q, state_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [VAL_W-1:0]      slot_val_q, slot_val_d;
    logic [NUM_DIGITS-1:0] slot_err_q, slot_err_d;
    logic                  valid_d, overrun_d;
    logic [VAL_W-1:0]      value_d;
    logic [NUM_DIGITS-1:0] err_d;
    logic                  complete_c, handshake_c;

    // Stability run: one capture per held, one-hot sample.
    always_comb begin
        same_c = (seg_q == seg_prev) && (dig_q == dig_prev);
        run_d  = run_q;
        if (!$onehot(dig_q)) begin
            run_d = '0;
        end else if (!same_c) begin
            run_d = RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
        cap_d = (run_d == RUN_MAX) && ((run_q != RUN_MAX) || !same_c);
    end

    // seg_prev/dig_prev hold the sample that cap_q refers to.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q    <= '0;
            dig_q    <= '0;
            seg_prev <= '0;
            dig_prev <= '0;
            run_q    <= '0;
            cap_q    <= 1'b0;
        end else begin
            seg_q    <= seg_in;
            dig_q    <= dig_en;
            seg_prev <= seg_q;
            dig_prev <= dig_q;
            run_q    <= run_d;
            cap_q    <= cap_d;
        end
    end

    seg7_to_nibble u_dec (
        .seg    (seg_prev),
        .nibble (cap_nib),
        .err    (cap_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            mask_q      <= '0;
            slot_val_q  <= '0;
            slot_err_q  <= '0;
            out_valid   <= 1'b0;
            out_value   <= '0;
            out_err     <= '0;
            out_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            slot_val_q  <= slot_val_d;
            slot_err_q  <= slot_err_d;
            out_valid   <= valid_d;
            out_value   <= value_d;
            out_err     <= err_d;
            out_overrun <= overrun_d;
        end
    end

    // Frame assembly and output register next-state.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        slot_val_d  = slot_val_q;
        slot_err_d  = slot_err_q;
        valid_d     = out_valid;
        value_d     = out_value;
        err_d       = out_err;
        overrun_d   = out_overrun;
        complete_c  = 1'b0;
        handshake_c = out_valid && out_ready;

        if (cap_q) begin
            case (state_q)
                SYNC: begin
                    if (dig_prev[0]) begin
                        slot_val_d[NIBBLE_W-1:0] = cap_nib;
                        slot_err_d[0]            = cap_err;
                        mask_d                   = NUM_DIGITS'(1);
                        state_d                  = COLLECT;
                    end
                end
                COLLECT: begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (dig_prev[i]) begin
                            slot_val_d[NIBBLE_W*i +: NIBBLE_W] = cap_nib;
                            slot_err_d[i]                      = cap_err;
                        end
                    end
                    // Digit 0 marks the start of a scan, so it restarts the frame.
                    mask_d = dig_prev[0] ? NUM_DIGITS'(1) : (mask_q | dig_prev);
                end
                default: state_d = SYNC;
            endcase

            if (&mask_d) begin
                complete_c = 1'b1;
                mask_d     = '0;
                state_d    = SYNC;
            end
        end

        if (complete_c && (!out_valid || handshake_c)) begin
            valid_d = 1'b1;
            value_d = slot_val_d;
            err_d   = slot_err_d;
            if (handshake_c) begin
                overrun_d = 1'b0;
            end
        end else if (complete_c) begin
            overrun_d = 1'b1;
        end else if (handshake_c) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: frame vector table plus
// hand-written glitch, backpressure and mid-frame reset sequences.
module tb_seg_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_en;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_value;
    logic [ND-1:0] out_err;
    logic          out_overrun;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_err     (out_err),
        .out_overrun (out_overrun)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] P [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BAD   = 7'b1111110;
    localparam logic [6:0] BLANK = 7'b1111111;

`ifdef SEG_SCAN_BLANK_ZERO_EN
    localparam logic [3:0] BLANK_ERR3 = 4'b0000;
`else
    localparam logic [3:0] BLANK_ERR3 = 4'b1000;
`endif

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
    } exp_t;

    typedef struct {
        logic [6:0]  seg [4];
        logic [15:0] v;
        logic [3:0]  e;
    } vec_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive digit d (negative = no digit) with pattern p for n cycles.
    task automatic show(input int d, input logic [6:0] p, input int n);
        dig_en = (d < 0) ? '0 : (ND'(1) << d);
        seg_in = p;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [6:0] s [4]);
        for (int d = 0; d < 4; d++) show(d, s[d], 5);
    endtask

    task automatic idle(input int n);
        show(-1, BLANK, n);
    endtask

    // Scoreboard: each accepted word is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h expected none", out_value);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("sb_value", 32'(out_value), 32'(x.v));
                chk("sb_err", 32'(out_err), 32'(x.e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        logic [6:0] s [4];

        vecs[0].seg = '{P[1], P[2], P[3], P[4]};   vecs[0].v = 16'h4321; vecs[0].e = 4'b0000;
        vecs[1].seg = '{P[0], P[5], BAD,  P[9]};   vecs[1].v = 16'h9050; vecs[1].e = 4'b0100;
        vecs[2].seg = '{P[7], P[8], P[9], BLANK};  vecs[2].v = 16'h0987; vecs[2].e = BLANK_ERR3;
        vecs[3].seg = '{P[12], P[0], P[15], P[11]}; vecs[3].v = 16'hBF0C; vecs[3].e = 4'b0000;

        reset     = 1'b1;
        out_ready = 1'b1;
        seg_in    = BLANK;
        dig_en    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_overrun", 32'(out_overrun), 0);
        reset = 1'b0;
        idle(2);

        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{v: vecs[k].v, e: vecs[k].e});
            scan(vecs[k].seg);
            idle(4);
        end

        // Short 8 on digit 1 must not be captured.
        sbq.push_back('{v: 16'hFE13, e: 4'b0000});
        show(0, P[3], 5);
        show(1, P[8], 2);
        show(1, P[1], 5);
        show(2, P[14], 5);
        show(3, P[15], 5);
        idle(4);

        // Backpressure: second frame dropped, overrun raised.
        out_ready = 1'b0;
        s = '{P[1], P[2], P[3], P[4]};
        scan(s);
        idle(3);
        chk("bp_valid1", 32'(out_valid), 1);
        chk("bp_value1", 32'(out_value), 32'h4321);
        chk("bp_overrun1", 32'(out_overrun), 0);
        s = '{P[5], P[6], P[7], P[8]};
        scan(s);
        idle(3);
        chk("bp_valid2", 32'(out_valid), 1);
        chk("bp_value2", 32'(out_value), 32'h4321);
        chk("bp_overrun2", 32'(out_overrun), 1);
        sbq.push_back('{v: 16'h4321, e: 4'b0000});
        out_ready = 1'b1;
        idle(1);
        chk("bp_valid_clr", 32'(out_valid), 0);
        chk("bp_overrun_clr", 32'(out_overrun), 0);
        idle(2);

        // Mid-frame reset while a word is held.
        out_ready = 1'b0;
        s = '{P[1], P[2], P[3], P[4]};
        scan(s);
        idle(2);
        chk("mr_held", 32'(out_valid), 1);
        show(0, P[5], 5);
        show(1, P[6], 5);
        reset = 1'b1;
        idle(2);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_value", 32'(out_value), 0);
        chk("mr_err", 32'(out_err), 0);
        chk("mr_overrun", 32'(out_overrun), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        // Digits 2,3 alone after reset must not complete a frame.
        show(2, P[7], 5);
        show(3, P[7], 5);
        idle(3);
        chk("mr_partial", 32'(out_valid), 0);
        sbq.push_back('{v: 16'hDCBA, e: 4'b0000});
        s = '{P[10], P[11], P[12], P[13]};
        scan(s);
        idle(4);

        chk("sb_drained", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
